counter_4bit_inc: RTL

COUNTER_4BIT_INC -- requirements
Module: counter_4bit_inc

---
 rtl/counter_4bit_inc_pkg.sv | 15 +
 rtl/counter_4bit_inc_incrementer_4bit.sv | 26 ++
 rtl/counter_4bit_inc.sv | 90 +++++++++
 3 files changed

// File: rtl/counter_4bit_inc_pkg.sv
// Shared constants and types for the 4-bit loadable up-counter.
package counter_4bit_inc_pkg;

  localparam int unsigned CNT_W           = 4;
  localparam int unsigned CNT_MAX_DEFAULT = 15;

  // Per-edge action of the counter, in priority order: load, wrap/increment, hold.
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_INC  = 2'd2,
    ACT_WRAP = 2'd3
  } cnt_act_e;

endpackage

// File: rtl/counter_4bit_inc_incrementer_4bit.sv
// incrementer_4bit: half-adder chain computing a + 1.
// s is the 4-bit sum; cout is the chain's carry c[3], high only when a == 4'hF.
module incrementer_4bit
  import counter_4bit_inc_pkg::*;
(
  input  logic [CNT_W-1:0] a,
  output logic [CNT_W-1:0] s,
  output logic             cout
);

  logic [CNT_W-1:0] c;

  // Ripple of half adders; the +1 enters as the carry-in of stage 0.
  for (genvar i = 0; i < CNT_W; i++) begin : g_stage
    if (i == 0) begin : g_lsb
      assign s[i] = ~a[i];
      assign c[i] = a[i];
    end else begin : g_rest
      assign s[i] = a[i] ^ c[i-1];
      assign c[i] = a[i] & c[i-1];
    end
  end

  assign cout = c[CNT_W-1];

endmodule

// File: rtl/counter_4bit_inc.sv
// counter_4bit_inc: 4-bit up-counter with synchronous load, terminal count
// and a one-cycle wrap pulse. Counts 0..MAX then wraps to 0.
// Optional feature: define CNT_OVF_STICKY_EN to add a sticky overflow flag
// (ovf) set on every wrap and cleared by ovf_clr; set wins over clear.
module counter_4bit_inc
  import counter_4bit_inc_pkg::*;
#(
  parameter int unsigned MAX = CNT_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [CNT_W-1:0] d,
`ifdef CNT_OVF_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf,
`endif
  output logic [CNT_W-1:0] q,
  output logic             tc,
  output logic             co
);

  localparam logic [CNT_W-1:0] MAX_Q = CNT_W'(MAX);
  // At MAX == 15 the incrementer carry-out is exactly the "q is at MAX" condition.
  localparam bit USE_CARRY = (MAX == CNT_MAX_DEFAULT);

  logic [CNT_W-1:0] sum;
  logic             cout;
  logic             at_max;
  cnt_act_e         act;
  logic [CNT_W-1:0] q_next;
  logic             co_next;

  incrementer_4bit u_inc (
    .a    (q),
    .s    (sum),
    .cout (cout)
  );

  assign at_max = USE_CARRY ? cout : (q == MAX_Q);
  assign tc     = (q == MAX_Q);

  // Decode the per-edge action and the next count value.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    act     = ACT_HOLD;
    q_next  = q;
    co_next = 1'b0;
    if (ld) begin
      act    = ACT_LOAD;
      q_next = (d > MAX_Q) ? '0 : d;
    end else if (en) begin
      if (at_max) begin
        act     = ACT_WRAP;
        q_next  = '0;
        co_next = 1'b1;
      end else begin
        act    = ACT_INC;
        q_next = sum;
      end
    end
  end

  // Count and wrap-pulse registers; reset clears them without waiting for clk.
  // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= '0;
      co <= 1'b0;
    end else begin
      q  <= q_next;
      co <= co_next;
    end
  end

`ifdef CNT_OVF_STICKY_EN
  // Sticky overflow: a wrap sets it, ovf_clr clears it only on a non-wrap edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (act == ACT_WRAP) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule
